// File: rtl/anti_theft_pkg.sv
// Shared types for the multi-door anti-theft controller: state codes and
// countdown timer selection.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        StArmed     = 3'd0,
        StTriggered = 3'd1,
        StAlarm     = 3'd2,
        StAlarmHold = 3'd3,
        StDisarmed  = 3'd4,
        StDrvOpen   = 3'd5,
        StArming    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TmrArm       = 2'd0,
        TmrDriver    = 2'd1,
        TmrPassenger = 2'd2,
        TmrAlarmOn   = 2'd3
    } tmr_sel_e;

    // States in which the countdown is live; everywhere else it sits at zero.
    function automatic logic is_timed(state_e s);
        return (s == StTriggered) || (s == StAlarmHold) || (s == StArming);
    endfunction

endpackage

// File: rtl/at_countdown.sv
// Tick-driven down-counter. A load takes priority over the tick on the same
// edge; expire flags the tick that takes the count from 1 to 0.
module at_countdown #(
    parameter int unsigned TIMER_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               clear,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               tick,
    output logic               expire
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    assign expire = tick && (cnt_q == TIMER_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anti_theft_fsm_n.sv
// Multi-door anti-theft controller: alarm FSM with integrated countdown,
// blinking status LED and latched hidden-switch fuel-pump interlock.
module anti_theft_fsm_n
    import anti_theft_pkg::*;
#(
    parameter int unsigned NUM_DOORS         = 2,
    parameter int unsigned TIMER_W           = 4,
    parameter int unsigned T_ARM_DELAY       = 6,
    parameter int unsigned T_DRIVER_DELAY    = 8,
    parameter int unsigned T_PASSENGER_DELAY = 15,
    parameter int unsigned T_ALARM_ON        = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic [NUM_DOORS-1:0] doors,
    input  logic                 ignition,
    input  logic                 hidden,
    input  logic                 brakepedal,
    output logic                 fuelpump,
    output logic                 status,
    output logic                 siren,
    output logic [2:0]           state_out
);

    localparam int unsigned TMax = (2 ** TIMER_W) - 1;

    if (NUM_DOORS < 1) begin : g_bad_doors
        $error("anti_theft_fsm_n: NUM_DOORS must be at least 1");
    end
    if ((T_ARM_DELAY < 1) || (T_ARM_DELAY > TMax) ||
        (T_DRIVER_DELAY < 1) || (T_DRIVER_DELAY > TMax) ||
        (T_PASSENGER_DELAY < 1) || (T_PASSENGER_DELAY > TMax) ||
        (T_ALARM_ON < 1) || (T_ALARM_ON > TMax)) begin : g_bad_delay
        $error("anti_theft_fsm_n: delay parameter outside 1..2^TIMER_W-1");
    end

    state_e             state_q, state_d;
    tmr_sel_e           tmr_sel;
    logic               tmr_load, tmr_clear, expire;
    logic [TIMER_W-1:0] load_value;
    logic               status_q, status_d;
    logic               siren_q, siren_d;
    logic               fuel_q, fuel_d;
    logic               any_open, drv;

    assign any_open = |doors;
    assign drv      = doors[0];

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_sel  = TmrArm;
        case (state_q)
            StArmed: begin
                if (ignition) begin
                    state_d = StDisarmed;
                end else if (any_open) begin
                    state_d  = StTriggered;
                    tmr_load = 1'b1;
                    tmr_sel  = drv ? TmrDriver : TmrPassenger;
                end
            end
            StTriggered: begin
                if (ignition)    state_d = StDisarmed;
                else if (expire) state_d = StAlarm;
            end
            StAlarm: begin
                if (ignition) begin
                    state_d = StDisarmed;
                end else if (!any_open) begin
                    state_d  = StAlarmHold;
                    tmr_load = 1'b1;
                    tmr_sel  = TmrAlarmOn;
                end
            end
            StAlarmHold: begin
                if (ignition)      state_d = StDisarmed;
                else if (any_open) state_d = StAlarm;
                else if (expire)   state_d = StArmed;
            end
            StDisarmed: begin
                if (!ignition && drv) state_d = StDrvOpen;
            end
            StDrvOpen: begin
                if (ignition) begin
                    state_d = StDisarmed;
                end else if (!any_open) begin
                    state_d  = StArming;
                    tmr_load = 1'b1;
                    tmr_sel  = TmrArm;
                end
            end
            StArming: begin
                if (ignition)      state_d = StDisarmed;
                else if (any_open) state_d = StDrvOpen;
                else if (expire)   state_d = StArmed;
            end
            default: state_d = StArmed;
        endcase
    end

    always_comb begin
        load_value = '0;
        unique case (tmr_sel)
            TmrArm:       load_value = TIMER_W'(T_ARM_DELAY);
            TmrDriver:    load_value = TIMER_W'(T_DRIVER_DELAY);
            TmrPassenger: load_value = TIMER_W'(T_PASSENGER_DELAY);
            TmrAlarmOn:   load_value = TIMER_W'(T_ALARM_ON);
            default:      load_value = '0;
        endcase
    end

    // Leaving a timed state by any route (ignition, door reopen) zeroes the count.
    assign tmr_clear = !is_timed(state_d);

    at_countdown #(
        .TIMER_W (TIMER_W)
    ) u_countdown (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .clear      (tmr_clear),
        .load_value (load_value),
        .tick       (tick),
        .expire     (expire)
    );

    always_comb begin
        siren_d  = (state_d == StAlarm) || (state_d == StAlarmHold);
        status_d = 1'b0;
        case (state_d)
            StArmed: begin
                // Blink only while resident in ARMED; entry always starts dark.
                if (state_q == StArmed) status_d = tick ? ~status_q : status_q;
                else                    status_d = 1'b0;
            end
            StTriggered, StAlarm, StAlarmHold: status_d = 1'b1;
            default:                           status_d = 1'b0;
        endcase
        // Ignition low always wins over a simultaneous set request.
        fuel_d = ignition ? (fuel_q | (hidden & brakepedal)) : 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StArmed;
            status_q <= 1'b0;
            siren_q  <= 1'b0;
            fuel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            siren_q  <= siren_d;
            fuel_q   <= fuel_d;
        end
    end

    assign state_out = state_q;
    assign status    = status_q;
    assign siren     = siren_q;
    assign fuelpump  = fuel_q;

endmodule

// File: tb/tb_anti_theft_fsm_n.sv
// Self-checking bench for anti_theft_fsm_n: vector table plus directed
// multi-cycle sequences for countdowns and asynchronous reset.
module tb_anti_theft_fsm_n;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [1:0] doors;
    logic       ignition, hidden, brakepedal;
    logic       fuelpump, status, siren;
    logic [2:0] state_out;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    anti_theft_fsm_n dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .doors      (doors),
        .ignition   (ignition),
        .hidden     (hidden),
        .brakepedal (brakepedal),
        .fuelpump   (fuelpump),
        .status     (status),
        .siren      (siren),
        .state_out  (state_out)
    );

    typedef struct {
        logic       tk;
        logic [1:0] dr;
        logic       ig;
        logic       hd;
        logic       bk;
        logic [2:0] st;
        logic       sr;
        logic       stat;
        logic       fp;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] st, input logic sr,
                             input logic stat, input logic fp);
        check({tag, ".state"}, {5'd0, state_out}, {5'd0, st});
        check({tag, ".siren"}, {7'd0, siren}, {7'd0, sr});
        check({tag, ".status"}, {7'd0, status}, {7'd0, stat});
        check({tag, ".fuelpump"}, {7'd0, fuelpump}, {7'd0, fp});
    endtask

    task automatic step(input logic t);
        tick = t;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; doors = 2'b00;
        ignition = 1'b0; hidden = 1'b0; brakepedal = 1'b0;

        //           tk  dr     ig  hd  bk  st    sr  stat fp
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        for (int i = 18; i < 23; i++)
            vecs[i] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clock);
        #1;
        check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            doors = vecs[i].dr; ignition = vecs[i].ig;
            hidden = vecs[i].hd; brakepedal = vecs[i].bk;
            step(vecs[i].tk);
            check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].sr, vecs[i].stat,
                      vecs[i].fp);
        end
        hidden = 1'b0; brakepedal = 1'b0;

        // Passenger door: 15-tick grace, then alarm, hold for 10 ticks after closing.
        doors = 2'b10;
        step(1'b0);
        check_out("pass.trig", 3'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 15; i++) begin
            step(1'b1);
            check("pass.count", {5'd0, state_out}, 8'd1);
            step(1'b0);
        end
        step(1'b1);
        check_out("pass.alarm", 3'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0);
        check_out("pass.alarm_open", 3'd2, 1'b1, 1'b1, 1'b0);
        doors = 2'b00;
        step(1'b0);
        check_out("pass.hold", 3'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++) begin
            step(1'b1);
            check("hold.count", {5'd0, state_out}, 8'd3);
        end
        step(1'b1);
        check_out("hold.rearm", 3'd0, 1'b0, 1'b0, 1'b0);

        // Both doors together: driver delay applies; ignition at tick 5 disarms.
        doors = 2'b11;
        step(1'b0);
        check_out("both.trig", 3'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            step(1'b1);
            check_out("both.count", 3'd1, 1'b0, 1'b1, 1'b0);
        end
        ignition = 1'b1;
        step(1'b1);
        check_out("both.disarm", 3'd4, 1'b0, 1'b0, 1'b0);
        ignition = 1'b0; doors = 2'b00;
        #2 reset_n = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;

        // Both doors again, left to run: alarm exactly on the 8th tick.
        doors = 2'b11;
        step(1'b0);
        check_out("drv.trig", 3'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1);
            check("drv.count", {5'd0, state_out}, 8'd1);
        end
        step(1'b1);
        check_out("drv.alarm", 3'd2, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset between edges while in ALARM.
        #3 reset_n = 1'b0;
        #1;
        check_out("areset.low", 3'd0, 1'b0, 1'b0, 1'b0);
        doors = 2'b00;
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        check("areset.cnt", {4'd0, dut.u_countdown.cnt_q}, 8'd0);
        step(1'b0);
        check_out("areset.idle", 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        check_out("areset.blink", 3'd0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
